// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: sequences IF/ID/EXE/MEM/WB and drives the
// datapath selects, write strobes and the 3-bit ALU Operation code.
module multicycle_control_unit #(
    parameter logic [5:0] OP_HALT  = 6'b111111,
    parameter bit         SHAMT_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] Operation,
    output logic [3:0] State,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_EXE_J  = 4'd5,
        S_MEM_LD = 4'd6,
        S_MEM_ST = 4'd7,
        S_WB_AL  = 4'd8,
        S_WB_LD  = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       is_rtype;
    logic       is_shift;
    logic       funct_ok;
    logic [2:0] funct_op;
    state_t     id_target;
    logic       id_legal;

    // Instruction decode shared by ID dispatch and the EXE-stage outputs.
    always_comb begin
        is_rtype = (Opcode == OP_RTYPE);
        is_shift = (Funct == FN_SLL) || (Funct == FN_SRL);
        funct_ok = 1'b1;
        funct_op = ALU_ADD;
        case (Funct)
            FN_ADD: funct_op = ALU_ADD;
            FN_SUB: funct_op = ALU_SUB;
            FN_SLT: funct_op = ALU_SLT;
            FN_AND: funct_op = ALU_AND;
            FN_OR:  funct_op = ALU_OR;
            FN_XOR: funct_op = ALU_XOR;
            FN_SLL: begin
                funct_op = ALU_SLL;
                funct_ok = SHAMT_EN;
            end
            FN_SRL: begin
                funct_op = ALU_SRL;
                funct_ok = SHAMT_EN;
            end
            default: funct_ok = 1'b0;
        endcase

        id_target = S_IF;
        id_legal  = 1'b1;
        if (Opcode == OP_HALT) begin
            id_target = S_HALT;
        end else begin
            case (Opcode)
                OP_RTYPE: begin
                    id_target = funct_ok ? S_EXE_AL : S_IF;
                    id_legal  = funct_ok;
                end
                OP_ADDI, OP_ORI: id_target = S_EXE_AL;
                OP_BEQ, OP_BNE:  id_target = S_EXE_BR;
                OP_LW, OP_SW:    id_target = S_EXE_LS;
                OP_J:            id_target = S_EXE_J;
                default:         id_legal  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = S_IF;
        illegal_d = illegal_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                state_d = id_target;
                if (!id_legal) begin
                    illegal_d = 1'b1;
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = (Opcode == OP_LW) ? S_MEM_LD : S_MEM_ST;
            S_EXE_J:  state_d = S_IF;
            S_MEM_LD: state_d = S_WB_LD;
            S_MEM_ST: state_d = S_IF;
            S_WB_AL:  state_d = S_IF;
            S_WB_LD:  state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    // Moore outputs; the write strobes are also forced low while reset is held.
    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        PCSrc     = 2'd0;
        Operation = ALU_ADD;
        case (state_q)
            S_IF: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'd1;
            end
            S_ID: begin
                ALUSrcB = 2'd2;
            end
            S_EXE_AL: begin
                if (is_rtype) begin
                    ALUSrcA   = is_shift ? 2'd2 : 2'd1;
                    ALUSrcB   = 2'd0;
                    Operation = funct_op;
                end else if (Opcode == OP_ORI) begin
                    ALUSrcA   = 2'd1;
                    ALUSrcB   = 2'd3;
                    Operation = ALU_OR;
                end else begin
                    ALUSrcA   = 2'd1;
                    ALUSrcB   = 2'd2;
                end
            end
            S_EXE_BR: begin
                ALUSrcA   = 2'd1;
                Operation = ALU_SUB;
                PCSrc     = 2'd1;
                PCWrite   = (Opcode == OP_BNE) ? ~Zero : Zero;
            end
            S_EXE_LS: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
            end
            S_EXE_J: begin
                PCSrc   = 2'd2;
                PCWrite = 1'b1;
            end
            S_MEM_ST: MemWrite = 1'b1;
            S_WB_AL: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            default: ;
        endcase
        if (!RST_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign State   = state_q;
    assign Illegal = illegal_q;

endmodule
